// File: rtl/debounce_sync_if.sv
// Bundle of the debouncer's enable, raw input and conditioned outputs.
// The master side drives en/raw and observes the outputs; the slave is the debouncer.
interface debounce_sync_if;
   logic en;
   logic raw;
   logic level;
   logic rise;
   logic fall;

   modport master (output en, output raw, input level, input rise, input fall);
   modport slave  (input en, input raw, output level, output rise, output fall);
endinterface

// File: rtl/debounce_sync.sv
// Switch/button conditioner: a multi-flop synchronizer followed by a 4-state
// debounce FSM. A new level is accepted only after STABLE_CYCLES consecutive
// equal synchronized samples. The FSM also emits one-cycle rise/fall strobes.
module debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   debounce_sync_if.slave   bus
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_RISE_WAIT = 2'd1,
      S_HIGH      = 2'd2,
      S_FALL_WAIT = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   level_reg, level_next;
   logic                   rise_reg, rise_next;
   logic                   fall_reg, fall_next;

   // Synchronizer shift chain; keeps sampling even while the FSM is paused.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.raw};
      end
   end

   assign s = sync_reg[SYNC_STAGES-1];

   // FSM state, stability counter and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= S_LOW;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   // Next-state logic: hold everything unless enabled; strobes default low.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      level_next = level_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      if (bus.en) begin
         case (state_reg)
            S_LOW: begin
               level_next = 1'b0;
               if (s) begin
                  state_next = S_RISE_WAIT;
                  cnt_next   = CNT_W'(1);
               end else begin
                  cnt_next   = '0;
               end
            end
            S_RISE_WAIT: begin
               if (!s) begin
                  // Glitch rejected: fall back without a strobe.
                  state_next = S_LOW;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_MAX) begin
                  state_next = S_HIGH;
                  cnt_next   = '0;
                  level_next = 1'b1;
                  rise_next  = 1'b1;
               end else begin
                  cnt_next   = cnt_reg + CNT_W'(1);
               end
            end
            S_HIGH: begin
               level_next = 1'b1;
               if (!s) begin
                  state_next = S_FALL_WAIT;
                  cnt_next   = CNT_W'(1);
               end else begin
                  cnt_next   = '0;
               end
            end
            S_FALL_WAIT: begin
               if (s) begin
                  state_next = S_HIGH;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_MAX) begin
                  state_next = S_LOW;
                  cnt_next   = '0;
                  level_next = 1'b0;
                  fall_next  = 1'b1;
               end else begin
                  cnt_next   = cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               // Unreachable encodings recover to a clean low state.
               state_next = S_LOW;
               cnt_next   = '0;
               level_next = 1'b0;
            end
         endcase
      end
   end

   assign bus.level = level_reg;
   assign bus.rise  = rise_reg;
   assign bus.fall  = fall_reg;

endmodule
